alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential integer ALU: single-cycle base ops, shift-add multiply and restoring
// divide iterating one bit per cycle, with a valid/ready handshake on both sides.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    logic [1:0]      state;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] hi_q, lo_q, opb_q, rs1_q, result_q;
    logic [2:0]      mf3_q;
    logic            neg_q, negr_q, dz_q, illegal_q;
    logic [4:0]      rd_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign illegal   = illegal_q;

    // Decode and single-cycle datapath, evaluated on the live inputs at acceptance.
    logic            is_r, is_i, is_m, legal, sra_sel;
    logic [XLEN-1:0] op2, base_res;
    logic [SHW-1:0]  shamt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_m     = is_r && (funct7 == F7_M);
        op2      = is_i ? imm : rs2;
        shamt    = op2[SHW-1:0];
        sra_sel  = is_i ? imm[10] : funct7[5];
        legal    = 1'b0;
        base_res = '0;
        if (is_r) begin
            if (funct7 == F7_BASE || funct7 == F7_M)
                legal = 1'b1;
            else if (funct7 == F7_ALT)
                legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if (is_i) begin
            case (funct3)
                3'b000:  legal = (funct7 != F7_ALT);
                3'b001:  legal = (imm[11:SHW] == '0);
                3'b101:  legal = !imm[11] && (imm[9:SHW] == '0);
                default: legal = 1'b1;
            endcase
        end
        case (funct3)
            3'b000:  base_res = (is_r && funct7 == F7_ALT) ? rs1 - op2 : rs1 + op2;
            3'b001:  base_res = rs1 << shamt;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op2))};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, (rs1 < op2)};
            3'b100:  base_res = rs1 ^ op2;
            3'b101:  base_res = sra_sel ? XLEN'($signed(rs1) >>> shamt) : rs1 >> shamt;
            3'b110:  base_res = rs1 | op2;
            default: base_res = rs1 & op2;
        endcase
    end

    // Multiply/divide operand preparation: magnitudes plus the signs to restore later.
    logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        is_div = funct3[2];
        sgn_a  = is_div ? !funct3[0] : (funct3 != 3'b011);
        sgn_b  = is_div ? !funct3[0] : (funct3[2:1] == 2'b00);
        a_neg  = sgn_a && rs1[XLEN-1];
        b_neg  = sgn_b && rs2[XLEN-1];
        mag_a  = a_neg ? -rs1 : rs1;
        mag_b  = b_neg ? -rs2 : rs2;
    end

    // One iteration step; hi/lo hold partial product + multiplier, or remainder + quotient.
    logic [XLEN:0]     msum, rsh, diff;
    logic [XLEN-1:0]   it_hi, it_lo, quo, rem, m_res;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rsh   = {hi_q, lo_q[XLEN-1]};
        diff  = rsh - {1'b0, opb_q};
        if (mf3_q[2]) begin
            it_hi = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], !diff[XLEN]};
        end else begin
            it_hi = msum[XLEN:1];
            it_lo = {msum[0], lo_q[XLEN-1:1]};
        end
        prod = {it_hi, it_lo};
        if (neg_q)
            prod = -prod;
        quo = neg_q  ? -it_lo : it_lo;
        rem = negr_q ? -it_hi : it_hi;
        case (mf3_q)
            3'b000:                m_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        m_res = dz_q ? '1 : quo;
            default:               m_res = dz_q ? rs1_q : rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rd_q <= rd;
                        if (!legal) begin
                            result_q  <= '0;
                            illegal_q <= 1'b1;
                            state     <= DONE;
                        end else if (is_m) begin
                            illegal_q <= 1'b0;
                            cnt       <= '0;
                            state     <= BUSY;
                        end else begin
                            result_q  <= base_res;
                            illegal_q <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN - 1)) begin
                        result_q <= m_res;
                        cnt      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the iteration datapath is deliberately not reset; it is always reloaded
    // on acceptance and only advances while the FSM is in BUSY.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            hi_q   <= '0;
            lo_q   <= is_div ? mag_a : mag_b;
            opb_q  <= is_div ? mag_b : mag_a;
            rs1_q  <= rs1;
            mf3_q  <= funct3;
            neg_q  <= a_neg ^ b_neg;
            negr_q <= a_neg;
            dz_q   <= (rs2 == '0);
        end else if (state == BUSY) begin
            hi_q <= it_hi;
            lo_q <= it_lo;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a table of hand-computed vectors plus hand-written
// sequences for output stall, reset during DONE and reset mid-divide.
module tb_alu_seq;

    localparam logic [6:0] OPR = 7'h33;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] F7A = 7'h20;
    localparam logic [6:0] F7M = 7'h01;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_err = 0;

    alu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .imm(imm), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_out(rd_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                input logic [4:0] rdv, input logic [31:0] exp, input logic ill,
                                input int lat);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.im = im;
        v.rd = rdv; v.exp = exp; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        opcode = v.opc; funct3 = v.f3; funct7 = v.f7;
        rs1 = v.a; rs2 = v.b; imm = v.im; rd = v.rd;
    endtask

    task automatic scramble();
        opcode = OPR; funct3 = 3'b000; funct7 = 7'h00;
        rs1 = $urandom; rs2 = $urandom; imm = $urandom; rd = 5'd31;
    endtask

    // Offers one op from IDLE, keeps in_valid high with junk while waiting, then acks.
    task automatic run_op(input vec_t v, output logic [31:0] res, output logic [4:0] rdo,
                          output logic ill, output int lat, output int busy_bad,
                          output logic ov_after, output logic ir_after);
        drive(v);
        @(posedge clk); #1;
        scramble();
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_bad++;
        in_valid = 1'b0;
        res = result; rdo = rd_out; ill = illegal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ov_after = out_valid;
        ir_after = in_ready;
    endtask

    vec_t        vt[$];
    logic [31:0] r;
    logic [4:0]  ro;
    logic        il, ova, ira, seen;
    int          lat, bb;

    initial begin
        // Base ops, R-type then I-type
        vt.push_back(mk(OPR, 3'b000, 7'h00, 32'd7,        32'hFFFFFFFE, 32'h0,        5'd3,  32'd5,        1'b0, 1));
        vt.push_back(mk(OPR, 3'b000, F7A,   32'd5,        32'd7,        32'h0,        5'd4,  32'hFFFFFFFE, 1'b0, 1));
        vt.push_back(mk(OPR, 3'b001, 7'h00, 32'd1,        32'h21,       32'h0,        5'd5,  32'd2,        1'b0, 1));
        vt.push_back(mk(OPR, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd6,  32'd1,        1'b0, 1));
        vt.push_back(mk(OPR, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd7,  32'd0,        1'b0, 1));
        vt.push_back(mk(OPR, 3'b100, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd8,  32'hFF00FF00, 1'b0, 1));
        vt.push_back(mk(OPR, 3'b101, F7A,   32'h80000000, 32'd31,       32'h0,        5'd9,  32'hFFFFFFFF, 1'b0, 1));
        vt.push_back(mk(OPI, 3'b110, 7'h00, 32'h00FF0000, 32'h12345678, 32'h00000F0F, 5'd10, 32'h00FF0F0F, 1'b0, 1));
        vt.push_back(mk(OPI, 3'b111, 7'h00, 32'hFFFF00FF, 32'h0,        32'hFFFFFFF0, 5'd11, 32'hFFFF00F0, 1'b0, 1));
        vt.push_back(mk(OPI, 3'b101, F7A,   32'h80000000, 32'h0,        32'h00000404, 5'd12, 32'hF8000000, 1'b0, 1));
        vt.push_back(mk(OPI, 3'b101, 7'h00, 32'h80000000, 32'h0,        32'h00000004, 5'd13, 32'h08000000, 1'b0, 1));
        vt.push_back(mk(OPI, 3'b000, 7'h00, 32'd0,        32'h5,        32'hFFFFFFFF, 5'd14, 32'hFFFFFFFF, 1'b0, 1));
        // Unsupported encodings
        vt.push_back(mk(OPI, 3'b000, F7A,   32'd9,        32'd1,        32'h00000400, 5'd15, 32'd0,        1'b1, 1));
        vt.push_back(mk(OPI, 3'b001, 7'h00, 32'd1,        32'd0,        32'h00000020, 5'd16, 32'd0,        1'b1, 1));
        vt.push_back(mk(OPI, 3'b101, 7'h00, 32'd1,        32'd0,        32'h00000804, 5'd17, 32'd0,        1'b1, 1));
        vt.push_back(mk(7'h37, 3'b000, 7'h00, 32'd1,      32'd1,        32'h0,        5'd18, 32'd0,        1'b1, 1));
        vt.push_back(mk(OPR, 3'b000, 7'h10, 32'd1,        32'd1,        32'h0,        5'd19, 32'd0,        1'b1, 1));
        vt.push_back(mk(OPR, 3'b100, F7A,   32'd1,        32'd1,        32'h0,        5'd20, 32'd0,        1'b1, 1));
        // Multiply
        vt.push_back(mk(OPR, 3'b000, F7M,   32'd7,        32'hFFFFFFFD, 32'h0,        5'd21, 32'hFFFFFFEB, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b001, F7M,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd22, 32'h00000000, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b011, F7M,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd23, 32'hFFFFFFFE, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b010, F7M,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd24, 32'hFFFFFFFF, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b001, F7M,   32'h40000000, 32'd4,        32'h0,        5'd25, 32'h00000001, 1'b0, 33));
        // Divide / remainder
        vt.push_back(mk(OPR, 3'b100, F7M,   32'h80000000, 32'hFFFFFFFF, 32'h0,        5'd26, 32'h80000000, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b110, F7M,   32'h80000000, 32'hFFFFFFFF, 32'h0,        5'd27, 32'h00000000, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b101, F7M,   32'd9,        32'd0,        32'h0,        5'd28, 32'hFFFFFFFF, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b111, F7M,   32'd9,        32'd0,        32'h0,        5'd29, 32'd9,        1'b0, 33));
        vt.push_back(mk(OPR, 3'b100, F7M,   32'hFFFFFFF9, 32'd2,        32'h0,        5'd30, 32'hFFFFFFFD, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b110, F7M,   32'hFFFFFFF9, 32'd2,        32'h0,        5'd1,  32'hFFFFFFFF, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b100, F7M,   32'hFFFFFFFB, 32'd0,        32'h0,        5'd2,  32'hFFFFFFFF, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b110, F7M,   32'hFFFFFFFB, 32'd0,        32'h0,        5'd3,  32'hFFFFFFFB, 1'b0, 33));
        vt.push_back(mk(OPR, 3'b101, F7M,   32'd100,      32'd7,        32'h0,        5'd4,  32'd14,       1'b0, 33));
        vt.push_back(mk(OPR, 3'b111, F7M,   32'd100,      32'd7,        32'h0,        5'd5,  32'd2,        1'b0, 33));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result",    64'(result),    64'd0);
        check("reset rd_out",    64'(rd_out),    64'd0);
        check("reset illegal",   64'(illegal),   64'd0);
        rst = 1'b0;
        n_vec++;

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i], r, ro, il, lat, bb, ova, ira);
            n_vec++;
            check($sformatf("v%0d result", i),       64'(r),   64'(vt[i].exp));
            check($sformatf("v%0d rd_out", i),       64'(ro),  64'(vt[i].rd));
            check($sformatf("v%0d illegal", i),      64'(il),  64'(vt[i].ill));
            check($sformatf("v%0d latency", i),      64'(lat), 64'(vt[i].lat));
            check($sformatf("v%0d in_ready busy", i), 64'(bb), 64'd0);
            check($sformatf("v%0d out_valid ack", i), 64'(ova), 64'd0);
            check($sformatf("v%0d in_ready ack", i),  64'(ira), 64'd1);
        end

        // Output stall: DONE held with out_ready low, new offers ignored
        drive(mk(OPR, 3'b000, 7'h00, 32'd100, 32'd23, 32'h0, 5'd9, 32'd0, 1'b0, 1));
        @(posedge clk); #1;
        n_vec++;
        for (int k = 0; k < 5; k++) begin
            scramble();
            check($sformatf("stall%0d out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d in_ready", k),  64'(in_ready),  64'd0);
            check($sformatf("stall%0d result", k),    64'(result),    64'd123);
            check($sformatf("stall%0d rd_out", k),    64'(rd_out),    64'd9);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release out_valid", 64'(out_valid), 64'd0);
        check("stall release in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("stall no queued op", 64'(out_valid), 64'd0);

        // Reset while DONE drops the pending result
        drive(mk(OPR, 3'b110, 7'h00, 32'h0000F000, 32'h0000000F, 32'h0, 5'd7, 32'd0, 1'b0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        check("done pre-reset result", 64'(result), 64'h0000F00F);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("done reset out_valid", 64'(out_valid), 64'd0);
        check("done reset result",    64'(result),    64'd0);
        check("done reset rd_out",    64'(rd_out),    64'd0);

        // Reset at BUSY cycle 10 of a DIV: no result may ever appear for it
        drive(mk(OPR, 3'b100, F7M, 32'd100, 32'd3, 32'h0, 5'd12, 32'd0, 1'b0, 33));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        repeat (9) @(posedge clk);
        #1;
        check("busy10 in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no out_valid", 64'(seen), 64'd0);
        run_op(mk(OPR, 3'b000, 7'h00, 32'd40, 32'd2, 32'h0, 5'd3, 32'd42, 1'b0, 1), r, ro, il, lat, bb, ova, ira);
        n_vec++;
        check("post-abort result",  64'(r),   64'd42);
        check("post-abort rd_out",  64'(ro),  64'd3);
        check("post-abort latency", 64'(lat), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
